// File: rtl/ram_reader.sv
// ram_reader: sequential read-back of the lab RAM.
// Checks word==address, sums words, flags completion.
module ram_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int N_WORDS = 169,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicio,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] x,
  output logic              x_valid,
  output logic [ERR_W-1:0]  erro_count,
  output logic [15:0]       soma,
  output logic              fim
);

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    DRENO,
    FIM
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

  state_t            state;
  state_t            state_nx;
  logic              start;
  logic              last;
  logic              bad;
  logic              rd_en_d;
  logic [ADDR_W-1:0] addr_d;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= OCIOSO;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      OCIOSO:  if (inicio) state_nx = LEITURA;
      LEITURA: if (last)   state_nx = DRENO;
      DRENO:               state_nx = FIM;
      FIM:     if (inicio) state_nx = LEITURA;
    endcase
  end

  // control strobes for the datapath
  always_comb begin
    start = inicio & ((state == OCIOSO) | (state == FIM));
    last  = (state == LEITURA) & (ram_addr == LAST);
    bad   = ram_rdata != DATA_W'(addr_d);
  end

  // address generator; compares before increment so no wrap at 2**ADDR_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_rd_en <= 1'b0;
    end else if (start) begin
      ram_addr  <= '0;
      ram_rd_en <= 1'b1;
    end else if (last) begin
      ram_rd_en <= 1'b0;
    end else if (ram_rd_en) begin
      ram_addr  <= ram_addr + 1'b1;
    end
  end

  // one-cycle delayed enable/address tag the returning read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en_d <= 1'b0;
      addr_d  <= '0;
    end else begin
      rd_en_d <= ram_rd_en;
      addr_d  <= ram_addr;
    end
  end

  // capture word, accumulate checksum and saturating error count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x          <= '0;
      x_valid    <= 1'b0;
      erro_count <= '0;
      soma       <= '0;
    end else begin
      x_valid <= rd_en_d;
      if (start) begin
        erro_count <= '0;
        soma       <= '0;
      end else if (rd_en_d) begin
        x    <= ram_rdata;
        soma <= soma + 16'(ram_rdata);
        if (bad && (erro_count != '1))
          erro_count <= erro_count + 1'b1;
      end
    end
  end

  // completion flag, raised with the last capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              fim <= 1'b0;
    else if (start)          fim <= 1'b0;
    else if (state == DRENO) fim <= 1'b1;
  end

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed + random sweeps of ram_reader
// against a RAM model and an arithmetic reference.
module tb_ram_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NW = 169;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inicio = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] x;
  logic          x_valid;
  logic [EW-1:0] erro_count;
  logic [15:0]   soma;
  logic          fim;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compared = 0;
  int mismatched = 0;

  ram_reader #(
    .ADDR_W(AW), .DATA_W(DW), .N_WORDS(NW), .ERR_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inicio(inicio),
    .ram_addr(ram_addr),
    .ram_rd_en(ram_rd_en),
    .ram_rdata(ram_rdata),
    .x(x),
    .x_valid(x_valid),
    .erro_count(erro_count),
    .soma(soma),
    .fim(fim)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_rd_en) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(output int e_err, output int e_soma,
                       output int e_x);
    e_err = 0;
    e_soma = 0;
    for (int i = 0; i < NW; i++) begin
      if (int'(mem[i]) != (i % (1 << DW))) e_err++;
      e_soma += int'(mem[i]);
    end
    if (e_err > (1 << EW) - 1) e_err = (1 << EW) - 1;
    e_soma = e_soma % 65536;
    e_x = int'(mem[NW-1]);
  endtask

  task automatic sweep(input string tag, input bit noisy);
    int edges, rd, pulses, ee, es, ex;
    logic [DW-1:0] hx;
    logic [15:0] hs;
    model(ee, es, ex);
    @(posedge clk); #1 inicio = 1'b1;
    @(posedge clk); #1 inicio = 1'b0;
    chk({tag, ".fim_drop"}, 32'(fim), 0);
    chk({tag, ".soma_clr"}, 32'(soma), 0);
    chk({tag, ".erro_clr"}, 32'(erro_count), 0);
    edges = 0;
    rd = int'(ram_rd_en);
    pulses = 0;
    while (!fim && edges < NW + 20) begin
      if (noisy) inicio = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      edges++;
      rd += int'(ram_rd_en);
      pulses += int'(x_valid);
    end
    inicio = 1'b0;
    chk({tag, ".fim_edges"}, 32'(edges), 32'(NW + 1));
    chk({tag, ".rd_cycles"}, 32'(rd), 32'(NW));
    chk({tag, ".pulses"}, 32'(pulses), 32'(NW));
    chk({tag, ".x"}, 32'(x), 32'(ex));
    chk({tag, ".erro"}, 32'(erro_count), 32'(ee));
    chk({tag, ".soma"}, 32'(soma), 32'(es));
    hx = x;
    hs = soma;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".fim_hold"}, 32'(fim), 1);
    chk({tag, ".x_hold"}, 32'(x), 32'(hx));
    chk({tag, ".soma_hold"}, 32'(soma), 32'(hs));
    chk({tag, ".xv_idle"}, 32'(x_valid), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".addr"}, 32'(ram_addr), 0);
    chk({tag, ".rd_en"}, 32'(ram_rd_en), 0);
    chk({tag, ".x"}, 32'(x), 0);
    chk({tag, ".xv"}, 32'(x_valid), 0);
    chk({tag, ".erro"}, 32'(erro_count), 0);
    chk({tag, ".soma"}, 32'(soma), 0);
    chk({tag, ".fim"}, 32'(fim), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);

    #2 reset = 1'b0;
    #10;
    check_zero("reset");
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle.rd_en", 32'(ram_rd_en), 0);

    sweep("base", 1'b0);
    chk("base.soma_const", 32'(soma), 32'h3774);

    mem[8'h10] = 8'hFF;
    sweep("corrupt", 1'b0);
    chk("corrupt.soma_const", 32'(soma), 32'h3863);
    chk("corrupt.erro_const", 32'(erro_count), 1);
    mem[8'h10] = 8'h10;

    @(posedge clk); #1 inicio = 1'b1;
    @(posedge clk); #1 inicio = 1'b0;
    for (int i = 0; i < 300 && ram_addr != 8'h40; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst.reach", 32'(ram_addr), 32'h40);
    #2 reset = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk) reset = 1'b1;
    sweep("after_rst", 1'b0);

    sweep("noisy", 1'b1);
    sweep("restart", 1'b0);
    chk("restart.soma_const", 32'(soma), 32'h3774);

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sweep("zero", 1'b0);
    chk("zero.erro_const", 32'(erro_count), 32'hA8);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < (1 << AW); i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                              : DW'(i);
      sweep($sformatf("rand%0d", r), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
